alu_result_accumulator: RTL and testbench
=========================================

# alu_result_accumulator

Downstream consumer of the 4-bit ALU's registered signed 5-bit result. Collects a window of ALU results over a valid/ready handshake and produces per-window statistics: a saturating signed sum, minimum, maximum, sample count and a sticky overflow flag. Results are held on an output valid/ready handshake. This is the stage between the ALU and any checker or host reading aggregated results.

## Interface
- N_SAMPLES, 4, samples per full window; legal range 2..16
- ACC_W, 8, width of the signed sum accumulator; legal range 6..16
- CNT_W, $clog2(N_SAMPLES+1), width of the count output; derived, do not override
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data holds an ALU result
- in_data  in  5  signed ALU result, two's complement, range -16..15
- in_last  in  1  qualified by in_valid; closes the window early after this sample
- in_ready  out  1  block accepts a sample this cycle
- out_valid  out  1  window statistics are valid
- out_ready  in  1  downstream accepts the statistics
- out_sum  out  ACC_W  signed saturating sum of the window
- out_min  out  5  signed minimum sample of the window
- out_max  out  5  signed maximum sample of the window
- out_count  out  CNT_W  number of samples in the window
- out_ovf  out  1  sticky; set if any accumulate step saturated

## Operation
- Two states: ACCUM and DONE. Reset state is ACCUM.
- in_ready = (state == ACCUM). out_valid = (state == DONE). Both are decoded from the state register only, with no combinational path from any input.
- An input transfer is in_valid && in_ready at a rising edge.
- On a transfer in ACCUM:
  - sum <= sat(sum + sext(in_data)). The addition is done at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - If clamping occurred, ovf <= 1. ovf is sticky for the rest of the window.
  - count <= count + 1.
  - First sample of a window (count == 0) loads both min and max with in_data. Later samples do signed compare-and-update.
  - If count+1 == N_SAMPLES, or in_last = 1, the next state is DONE.
- If in_valid = 0 in ACCUM, no state changes. Gaps between samples are allowed.
- DONE:
  - in_valid and in_last are ignored.
  - All out_* hold stable until out_ready = 1.
  - On the out_ready handshake, clear sum, count, min, max and ovf to 0 and return to ACCUM.
- out_sum, out_min, out_max, out_count and out_ovf are the internal registers driven directly. In ACCUM they show partial values, which are meaningful only while out_valid = 1.
- A sample arriving in the same cycle as the DONE handshake is not accepted, because in_ready = 0 in that cycle.

## Timing
- Reset value of every output: in_ready = 1, out_valid = 0, out_sum = 0, out_min = 0, out_max = 0, out_count = 0, out_ovf = 0.
- Reset is asynchronous on assertion. It is released by the bench on a falling edge of clk.
- Latency: out_valid rises on the same rising edge that accepts the final sample, so it is visible in the following cycle.
- The minimum window period is N_SAMPLES + 1 cycles: N accept cycles plus 1 DONE cycle with out_ready held high.
- Reset asserted mid-window discards the partial window and returns to ACCUM with all registers 0.
- in_last together with count+1 == N_SAMPLES behaves as a normal full window.
- in_last on the first sample produces a 1-sample window: count = 1, min = max = sum = sample.

## Test plan
- Reset: hold reset = 0 for 2 cycles -> in_ready = 1, out_valid = 0, all out_* = 0.
- Full window (N = 4, ACC_W = 8): samples 3, -2, 15, -16 -> out_sum = 0, out_min = -16, out_max = 15, out_count = 4, out_ovf = 0. out_valid is high in the cycle after the 4th accept.
- Saturation (ACC_W = 6): samples 15, 15, 15, -16 -> running sums 15, 30, 31 (clamped), 15. Final out_sum = 15, out_ovf = 1.
- Backpressure: after a full window, hold out_ready = 0 for 5 cycles while driving in_valid = 1 -> out_* stable, in_ready = 0, nothing accepted. Then raise out_ready -> one cycle later in_ready = 1 and out_count = 0.
- Early close: samples 7, then -3 with in_last = 1 -> out_sum = 4, out_min = -3, out_max = 7, out_count = 2.
- Mid-window reset: accept 5 and 6, then pulse reset = 0 -> all outputs 0. The next 4 samples, all -1, give out_sum = -4 and out_count = 4.

Source files
------------

// File: rtl/alu_result_accumulator.sv
// alu_result_accumulator: windowed saturating sum/min/max/count/overflow statistics over ALU results
module alu_result_accumulator #(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W = 8,
  localparam int CNT_W = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [4:0]       in_data_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_sum_o,
  output logic [4:0]       out_min_o,
  output logic [4:0]       out_max_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic             out_ovf_o
);
  localparam logic ACCUM = 1'b0;
  localparam logic DONE = 1'b1;
  logic state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [4:0] min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic xfer, clear, first, sat, close;
  logic [ACC_W:0] wide;
  logic [ACC_W-1:0] clamped;
  always_comb begin
    xfer = in_valid_i && state_q == ACCUM;
    clear = out_ready_i && state_q == DONE;
    first = count_q == '0;
    wide = {sum_q[ACC_W-1], sum_q} + {{(ACC_W-4){in_data_i[4]}}, in_data_i};
    sat = wide[ACC_W] != wide[ACC_W-1];
    clamped = sat ? (wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : wide[ACC_W-1:0];
    close = in_last_i || count_q == CNT_W'(N_SAMPLES - 1);
    sum_d = clear ? '0 : xfer ? clamped : sum_q;
    ovf_d = clear ? 1'b0 : (xfer && sat) | ovf_q;
    count_d = clear ? '0 : xfer ? count_q + CNT_W'(1) : count_q;
    min_d = clear ? '0 : !xfer ? min_q : (first || $signed(in_data_i) < $signed(min_q)) ? in_data_i : min_q;
    max_d = clear ? '0 : !xfer ? max_q : (first || $signed(in_data_i) > $signed(max_q)) ? in_data_i : max_q;
    state_d = clear ? ACCUM : (xfer && close) ? DONE : state_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACCUM;
      sum_q <= '0;
      min_q <= '0;
      max_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready_o = state_q == ACCUM;
  assign out_valid_o = state_q == DONE;
  assign out_sum_o = sum_q;
  assign out_min_o = min_q;
  assign out_max_o = max_q;
  assign out_count_o = count_q;
  assign out_ovf_o = ovf_q;
endmodule

// File: tb/tb_alu_result_accumulator.sv
// tb_alu_result_accumulator: directed checks of an ACC_W=8 and an ACC_W=6 instance driven in lockstep
module tb_alu_result_accumulator;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [4:0] in_data = '0;
  logic in_ready_a, out_valid_a, ovf_a, in_ready_b, out_valid_b, ovf_b;
  logic [7:0] sum_a;
  logic [5:0] sum_b;
  logic [4:0] min_a, max_a, min_b, max_b;
  logic [2:0] cnt_a, cnt_b;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  alu_result_accumulator #(.N_SAMPLES(4), .ACC_W(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last),
    .in_ready_o(in_ready_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_sum_o(sum_a),
    .out_min_o(min_a), .out_max_o(max_a), .out_count_o(cnt_a), .out_ovf_o(ovf_a));
  alu_result_accumulator #(.N_SAMPLES(4), .ACC_W(6)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last),
    .in_ready_o(in_ready_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_sum_o(sum_b),
    .out_min_o(min_b), .out_max_o(max_b), .out_count_o(cnt_b), .out_ovf_o(ovf_b));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push(input int d, input logic l);
    in_valid = 1'b1;
    in_data = 5'(d);
    in_last = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic win_a(input string tag, input int s, input int mn, input int mx, input int c, input int o);
    chk({tag, " valid"}, int'(out_valid_a), 1);
    chk({tag, " sum"}, int'($signed(sum_a)), s);
    chk({tag, " min"}, int'($signed(min_a)), mn);
    chk({tag, " max"}, int'($signed(max_a)), mx);
    chk({tag, " count"}, int'(cnt_a), c);
    chk({tag, " ovf"}, int'(ovf_a), o);
  endtask
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " drain ready"}, int'(in_ready_a), 1);
    chk({tag, " drain valid"}, int'(out_valid_a), 0);
    chk({tag, " drain count"}, int'(cnt_a), 0);
    chk({tag, " drain sum"}, int'(sum_a), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst ready", int'(in_ready_a), 1);
    chk("rst valid", int'(out_valid_a), 0);
    chk("rst sum", int'(sum_a), 0);
    chk("rst min", int'(min_a), 0);
    chk("rst max", int'(max_a), 0);
    chk("rst count", int'(cnt_a), 0);
    chk("rst ovf", int'(ovf_a), 0);
    rst_n = 1'b1;
    @(negedge clk);
    push(3, 0); push(-2, 0); push(15, 0);
    chk("full early valid", int'(out_valid_a), 0);
    chk("full partial count", int'(cnt_a), 3);
    push(-16, 0);
    win_a("full", 0, -16, 15, 4, 0);
    chk("full ready", int'(in_ready_a), 0);
    chk("full b sum", int'($signed(sum_b)), 0);
    chk("full b ovf", int'(ovf_b), 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 5'd9;
      @(negedge clk);
      chk("bp valid", int'(out_valid_a), 1);
      chk("bp ready", int'(in_ready_a), 0);
      chk("bp count", int'(cnt_a), 4);
      chk("bp sum", int'($signed(sum_a)), 0);
      chk("bp min", int'($signed(min_a)), -16);
    end
    in_valid = 1'b0;
    drain("bp");
    push(15, 0); push(15, 0); push(15, 0); push(-16, 0);
    chk("sat b valid", int'(out_valid_b), 1);
    chk("sat b sum", int'($signed(sum_b)), 15);
    chk("sat b ovf", int'(ovf_b), 1);
    chk("sat b min", int'($signed(min_b)), -16);
    chk("sat b max", int'($signed(max_b)), 15);
    win_a("sat a", 29, -16, 15, 4, 0);
    drain("sat");
    chk("sat b ovf cleared", int'(ovf_b), 0);
    push(7, 0); push(-3, 1);
    win_a("early", 4, -3, 7, 2, 0);
    drain("early");
    push(-7, 1);
    win_a("single", -7, -7, -7, 1, 0);
    drain("single");
    push(1, 0); push(2, 0); push(3, 0); push(4, 1);
    win_a("last4", 10, 1, 4, 4, 0);
    drain("last4");
    push(5, 0); push(6, 0);
    rst_n = 1'b0;
    #1;
    chk("mid rst sum", int'(sum_a), 0);
    chk("mid rst count", int'(cnt_a), 0);
    chk("mid rst min", int'(min_a), 0);
    chk("mid rst max", int'(max_a), 0);
    chk("mid rst ready", int'(in_ready_a), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(-1, 0); push(-1, 0); push(-1, 0); push(-1, 0);
    win_a("after rst", -4, -1, -1, 4, 0);
    drain("after rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
